// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I core: FSM states, opcodes,
// data-memory access encodings and the integer ALU function.
package riscv_mc_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  // DMCtrl is the load/store funct3 field
  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'b000:  alu = alt ? x - y : x + y;
      3'b001:  alu = x << y[4:0];
      3'b010:  alu = {31'b0, $signed(x) < $signed(y)};
      3'b011:  alu = {31'b0, x < y};
      3'b100:  alu = x ^ y;
      3'b101:  alu = alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'b110:  alu = x | y;
      default: alu = x & y;
    endcase
  endfunction

endpackage

// File: rtl/mc_lsu_align.sv
// Byte-lane alignment for the shared bus: store lane replication and byte
// enables, load lane extraction with sign/zero extension, misalignment check.
module mc_lsu_align
  import riscv_mc_pkg::*;
(
  input  logic [2:0]  dm_ctrl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  // Replicating the datum across lanes is equivalent to shifting it by the
  // byte offset, because only the enabled lanes are written.
  always_comb begin
    wdata      = store_data;
    be         = 4'b1111;
    misaligned = 1'b0;
    case (dm_ctrl[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata      = {2{store_data[15:0]}};
        be         = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (dm_ctrl)
      DM_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      DM_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      DM_BU:   load_data = {24'b0, shifted[7:0]};
      DM_HU:   load_data = {16'b0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I core sequenced over a single valid/ready memory bus.
// Holding registers IR/A/B/IMM/ALUOut/MDR carry state between FSM steps.
module riscv_multicycle_core
  import riscv_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned INSTRET_WIDTH = 32,
  parameter bit          HALT_ON_ECALL = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  output logic                     halted,
  output logic                     misalign,
  output logic [INSTRET_WIDTH-1:0] instret,
  output logic [31:0]              pc_dbg
);

  state_t      state;
  logic [31:0] pc, ir, a, b, imm, alu_out, mdr;
  logic [31:0] regs [1:31];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, imm_gen, alu_res, target, pc_plus4, wb_data;
  logic [31:0] jalr_sum, lsu_wdata, load_data;
  logic [3:0]  lsu_be;
  logic        br_taken, is_jump, rd_we, lsu_misaligned;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign pc_plus4 = pc + 32'd4;
  assign is_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];

  always_comb begin
    case (opcode)
      OP_STORE:         imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:        imm_gen = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_JAL:           imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OP_LUI, OP_AUIPC: imm_gen = {ir[31:12], 12'b0};
      default:          imm_gen = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  always_comb begin
    alu_res = a + imm;
    case (opcode)
      OP_OP:    alu_res = alu(funct3, ir[30], a, b);
      OP_OPIMM: alu_res = alu(funct3, (funct3 == 3'b101) && ir[30], a, imm);
      OP_LUI:   alu_res = imm;
      OP_AUIPC: alu_res = pc + imm;
      default:  ;
    endcase
  end

  assign jalr_sum = a + imm;
  assign target   = (opcode == OP_JALR) ? (jalr_sum & ~32'd1) : pc + imm;

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (a == b);
      3'b001:  br_taken = (a != b);
      3'b100:  br_taken = ($signed(a) < $signed(b));
      3'b101:  br_taken = ($signed(a) >= $signed(b));
      3'b110:  br_taken = (a < b);
      3'b111:  br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_LOAD, OP_JAL, OP_JALR: rd_we = 1'b1;
      default: rd_we = 1'b0;
    endcase
    if (opcode == OP_LOAD) wb_data = mdr;
    else if (is_jump)      wb_data = pc_plus4;
    else                   wb_data = alu_out;
  end

  mc_lsu_align u_lsu (
    .dm_ctrl    (funct3),
    .addr_lo    (alu_out[1:0]),
    .store_data (b),
    .rdata      (mem_rdata),
    .wdata      (lsu_wdata),
    .be         (lsu_be),
    .load_data  (load_data),
    .misaligned (lsu_misaligned)
  );

  // Gating with reset drops the request asynchronously mid-transfer.
  assign mem_req   = !reset && ((state == FETCH) || (state == MEM && !lsu_misaligned));
  assign mem_we    = (state == MEM) && (opcode == OP_STORE);
  assign mem_addr  = (state == MEM) ? {alu_out[31:2], 2'b00} : pc;
  assign mem_wdata = lsu_wdata;
  assign mem_be    = mem_we ? lsu_be : 4'b0000;
  assign halted    = (state == HALT);
  assign pc_dbg    = pc;

  always_ff @(posedge clk) begin
    if (state == WB && rd_we && rd != 5'd0) regs[rd] <= wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      imm      <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      misalign <= 1'b0;
      instret  <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir    <= mem_rdata;
          state <= DECODE;
        end
        DECODE: begin
          a     <= rs1_val;
          b     <= rs2_val;
          imm   <= imm_gen;
          state <= EXECUTE;
        end
        EXECUTE: begin
          alu_out <= alu_res;
          case (opcode)
            OP_BRANCH:
              if (br_taken && target[1:0] != 2'b00) begin
                misalign <= 1'b1;
                state    <= HALT;
              end else begin
                pc      <= br_taken ? target : pc_plus4;
                instret <= instret + 1'b1;
                state   <= FETCH;
              end
            OP_JAL, OP_JALR:
              if (target[1:0] != 2'b00) begin
                misalign <= 1'b1;
                state    <= HALT;
              end else begin
                alu_out <= target;
                state   <= WB;
              end
            OP_LOAD, OP_STORE: state <= MEM;
            OP_SYSTEM:
              if (HALT_ON_ECALL) begin
                instret <= instret + 1'b1;
                state   <= HALT;
              end else begin
                state <= WB;
              end
            default: state <= WB;
          endcase
        end
        MEM:
          if (lsu_misaligned) begin
            misalign <= 1'b1;
            state    <= HALT;
          end else if (mem_ready) begin
            if (opcode == OP_STORE) begin
              pc      <= pc_plus4;
              instret <= instret + 1'b1;
              state   <= FETCH;
            end else begin
              mdr   <= load_data;
              state <= WB;
            end
          end
        WB: begin
          pc      <= is_jump ? alu_out : pc_plus4;
          instret <= instret + 1'b1;
          state   <= FETCH;
        end
        HALT:    ;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: program ROM below 0x100, data RAM
// at 0x100-0x1FF, configurable wait states and bus-protocol monitoring.
module tb_riscv_multicycle_core;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, halted, misalign;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instret, pc_dbg;
  logic [3:0]  mem_be;

  logic [31:0] rom [0:63];
  logic [31:0] ram [0:63];
  int unsigned waits, wcnt, xfers, proto_errs;
  logic        held, got_first, h_we;
  logic [31:0] h_addr, h_wdata, first_addr;
  logic [3:0]  h_be;
  logic [3:0]  be_log [$];
  int unsigned errors = 0, checks = 0;

  always #5 clk = ~clk;

  riscv_multicycle_core #(.RESET_PC(RST_PC), .INSTRET_WIDTH(32), .HALT_ON_ECALL(1'b1)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .halted(halted), .misalign(misalign), .instret(instret), .pc_dbg(pc_dbg)
  );

  assign mem_ready = mem_req && (wcnt >= waits);
  assign mem_rdata = mem_addr[8] ? ram[mem_addr[7:2]] : rom[mem_addr[7:2]];

  always @(posedge clk) begin
    if (reset) begin
      wcnt <= 0;
      xfers = 0;
      proto_errs = 0;
      held = 1'b0;
      got_first = 1'b0;
      be_log.delete();
      for (int i = 0; i < 64; i++) ram[i] = '0;
    end else begin
      if (held && mem_req && (mem_addr !== h_addr || mem_we !== h_we ||
                              mem_be !== h_be || mem_wdata !== h_wdata))
        proto_errs++;
      if (mem_req && !got_first) begin
        first_addr = mem_addr;
        got_first  = 1'b1;
      end
      if (mem_req && mem_ready) begin
        xfers++;
        if (mem_we) begin
          for (int k = 0; k < 4; k++)
            if (mem_be[k] && mem_addr[8]) ram[mem_addr[7:2]][8*k +: 8] = mem_wdata[8*k +: 8];
          be_log.push_back(mem_be);
        end else if (mem_be != 4'b0000) begin
          proto_errs++;
        end
      end
      held    = mem_req && !mem_ready;
      h_addr  = mem_addr;
      h_we    = mem_we;
      h_be    = mem_be;
      h_wdata = mem_wdata;
      wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
    end
  end

  function automatic logic [31:0] enc_i(input logic [31:0] im, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {im[11:0], r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] im, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
    return {im[11:5], r2, r1, f3, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] im, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
    return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] im, input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] r1,
                                       input logic [31:0] im);
    return enc_i(im, r1, 3'b000, rd, 7'b0010011);
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = EBREAK;
  endtask

  task automatic do_reset(input int unsigned w);
    reset = 1'b1;
    waits = w;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int unsigned bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      if (halted) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic cycles_to_instret(input logic [31:0] n, output int cyc);
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (instret == n) begin cyc = c; break; end
    end
  endtask

  task automatic load_alu_prog();
    clear_rom();
    rom[0] = addi(5'd1, 5'd0, 32'd5);
    rom[1] = addi(5'd2, 5'd1, -32'sd3);
    rom[2] = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
    rom[3] = enc_s(32'h100, 5'd3, 5'd0, 3'b010);
    rom[4] = EBREAK;
  endtask

  task automatic test_reset();
    load_alu_prog();
    reset = 1'b1;
    waits = 0;
    @(negedge clk); @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
    checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL reset_be: got %b want 0000", mem_be); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
    checks++; if (pc_dbg !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_dbg, RST_PC); end
    reset = 1'b0;
  endtask

  task automatic test_alu(input int unsigned w);
    int cyc;
    bit ok;
    load_alu_prog();
    do_reset(w);
    cycles_to_instret(32'd3, cyc);
    // zero-wait ALU ops take 4 cycles each; each of the three fetches stalls w cycles
    checks++; if (cyc != 12 + 3 * int'(w)) begin errors++; $display("FAIL alu_cycles_w%0d: got %0d want %0d", w, cyc, 12 + 3 * w); end
    checks++; if (first_addr !== RST_PC) begin errors++; $display("FAIL first_addr_w%0d: got %h want %h", w, first_addr, RST_PC); end
    wait_halt(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL alu_halt_timeout_w%0d: got running want halted", w); end
    checks++; if (ram[0] !== 32'd7) begin errors++; $display("FAIL alu_x3_w%0d: got %h want 00000007", w, ram[0]); end
    checks++; if (instret !== 32'd5) begin errors++; $display("FAIL alu_instret_w%0d: got %0d want 5", w, instret); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL ebreak_misalign_w%0d: got %b want 0", w, misalign); end
    checks++; if (proto_errs != 0) begin errors++; $display("FAIL bus_stable_w%0d: got %0d violations want 0", w, proto_errs); end
  endtask

  task automatic test_lsu();
    bit ok;
    clear_rom();
    rom[0] = {20'h12345, 5'd3, 7'b0110111};
    rom[1] = addi(5'd3, 5'd3, 32'h678);
    rom[2] = enc_s(32'h100, 5'd3, 5'd0, 3'b010);
    rom[3] = enc_s(32'h101, 5'd0, 5'd0, 3'b000);
    rom[4] = enc_i(32'h102, 5'd0, 3'b100, 5'd4, 7'b0000011);
    rom[5] = enc_i(32'h100, 5'd0, 3'b001, 5'd5, 7'b0000011);
    rom[6] = enc_s(32'h104, 5'd4, 5'd0, 3'b010);
    rom[7] = enc_s(32'h108, 5'd5, 5'd0, 3'b010);
    rom[8] = EBREAK;
    do_reset(1);
    wait_halt(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lsu_halt_timeout: got running want halted"); end
    checks++; if (be_log.size() < 2 || be_log[0] !== 4'b1111) begin errors++; $display("FAIL sw_be: got %0d entries want be 1111", be_log.size()); end
    checks++; if (be_log.size() < 2 || be_log[1] !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b want 0010", (be_log.size() > 1) ? be_log[1] : 4'bxxxx); end
    checks++; if (ram[0] !== 32'h1234_0078) begin errors++; $display("FAIL word_0x100: got %h want 12340078", ram[0]); end
    checks++; if (ram[1] !== 32'h0000_0034) begin errors++; $display("FAIL lbu_x4: got %h want 00000034", ram[1]); end
    checks++; if (ram[2] !== 32'h0000_0078) begin errors++; $display("FAIL lh_x5: got %h want 00000078", ram[2]); end
    checks++; if (instret !== 32'd9) begin errors++; $display("FAIL lsu_instret: got %0d want 9", instret); end
  endtask

  task automatic test_branch();
    int cyc;
    bit ok;
    clear_rom();
    rom[0]  = addi(5'd2, 5'd0, 32'd0);
    rom[1]  = addi(5'd1, 5'd0, 32'd3);
    rom[2]  = addi(5'd1, 5'd1, -32'sd1);
    rom[3]  = enc_b(-32'sd4, 5'd0, 5'd1, 3'b001);
    rom[4]  = enc_b(32'd8, 5'd0, 5'd0, 3'b000);
    rom[5]  = addi(5'd2, 5'd0, 32'd99);
    rom[6]  = enc_j(32'd16, 5'd5);
    rom[7]  = addi(5'd2, 5'd0, 32'd77);
    rom[8]  = addi(5'd2, 5'd0, 32'd77);
    rom[9]  = addi(5'd2, 5'd0, 32'd77);
    rom[10] = enc_s(32'h100, 5'd5, 5'd0, 3'b010);
    rom[11] = enc_s(32'h104, 5'd2, 5'd0, 3'b010);
    rom[12] = EBREAK;
    do_reset(0);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (pc_dbg == 32'h0C) begin ok = 1'b1; break; end
    end
    cyc = -1;
    for (int c = 1; c <= 20 && ok; c++) begin
      @(posedge clk); #1;
      if (pc_dbg != 32'h0C) begin cyc = c; break; end
    end
    checks++; if (cyc != 3) begin errors++; $display("FAIL taken_cycles: got %0d want 3", cyc); end
    checks++; if (pc_dbg !== 32'h08) begin errors++; $display("FAIL taken_target: got %h want 00000008", pc_dbg); end
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (pc_dbg == 32'h10) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!ok || instret !== 32'd8) begin errors++; $display("FAIL not_taken_pc: got pc %h instret %0d want 00000010 and 8", pc_dbg, instret); end
    wait_halt(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL branch_halt_timeout: got running want halted"); end
    checks++; if (ram[0] !== 32'h1C) begin errors++; $display("FAIL jal_link: got %h want 0000001c", ram[0]); end
    checks++; if (ram[1] !== 32'h0) begin errors++; $display("FAIL skipped_writes: got %h want 00000000", ram[1]); end
    checks++; if (instret !== 32'd13) begin errors++; $display("FAIL branch_instret: got %0d want 13", instret); end
  endtask

  task automatic test_misalign();
    bit ok;
    clear_rom();
    rom[0] = addi(5'd1, 5'd0, 32'h102);
    rom[1] = enc_i(32'd0, 5'd1, 3'b010, 5'd2, 7'b0000011);
    do_reset(0);
    wait_halt(100, ok);
    checks++; if (!ok || misalign !== 1'b1) begin errors++; $display("FAIL lw_misalign: got halted %b misalign %b want 1 1", halted, misalign); end
    checks++; if (xfers != 2) begin errors++; $display("FAIL lw_no_req: got %0d transfers want 2", xfers); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL lw_instret: got %0d want 1", instret); end
    clear_rom();
    rom[0] = addi(5'd1, 5'd0, 32'h22);
    rom[1] = enc_i(32'd0, 5'd1, 3'b000, 5'd0, 7'b1100111);
    do_reset(0);
    wait_halt(100, ok);
    checks++; if (!ok || misalign !== 1'b1) begin errors++; $display("FAIL jalr_misalign: got halted %b misalign %b want 1 1", halted, misalign); end
    checks++; if (pc_dbg !== 32'h04) begin errors++; $display("FAIL jalr_pc: got %h want 00000004", pc_dbg); end
  endtask

  task automatic test_reset_mid_fetch();
    int cyc;
    bit ok;
    load_alu_prog();
    do_reset(0);
    cycles_to_instret(32'd2, cyc);
    waits = 5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h08) begin errors++; $display("FAIL stalled_fetch: got req %b addr %h want 1 00000008", mem_req, mem_addr); end
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL async_req_drop: got %b want 0", mem_req); end
    checks++; if (instret !== 32'd0 || pc_dbg !== RST_PC) begin errors++; $display("FAIL async_state: got instret %0d pc %h want 0 %h", instret, pc_dbg, RST_PC); end
    @(negedge clk); @(negedge clk);
    waits = 0;
    reset = 1'b0;
    wait_halt(200, ok);
    checks++; if (!ok || first_addr !== RST_PC || ram[0] !== 32'd7) begin errors++; $display("FAIL refetch: got first %h x3 %h want %h 00000007", first_addr, ram[0], RST_PC); end
    checks++; if (instret !== 32'd5) begin errors++; $display("FAIL refetch_instret: got %0d want 5", instret); end
  endtask

  initial begin
    test_reset();
    test_alu(0);
    test_alu(3);
    test_lsu();
    test_branch();
    test_misalign();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
